// File: rtl/usb_spi_master_if.sv
// Avalon-MM slave bus bundle for the USB SPI master: word-addressed registers,
// active-low strobes, registered read data and the transfer-done interrupt.
interface usb_spi_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/usb_spi_master.sv
// Avalon-MM controlled SPI mode-0 byte master for an external USB controller:
// programmable SCK divider, software chip select, done interrupt.
module usb_spi_master (
  input  logic            clk,
  input  logic            reset_n,
  usb_spi_master_if.slave bus,
  output logic            usb_sck,
  output logic            usb_sdi,
  output logic            usb_scs_n,
  input  logic            usb_sdo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  div_r, hp_cnt_r, hp_cnt_s;
  logic [7:0]  shift_r, shift_s, rx_byte_r, rx_byte_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic        sck_r, sck_s, sdi_r, sdi_s, busy_r, busy_s;
  logic        cs_en_r, irq_en_r, rx_valid_r, overrun_r, done_r, irq_r;
  logic        sdo_meta_r, sdo_sync_r;
  logic [31:0] readdata_r, rd_mux_s;
  logic        wr_s, rd_s, data_wr_s, data_rd_s, status_wr_s, ctrl_wr_s, done_wr_s;
  logic        complete_s, overrun_evt_s;

  assign wr_s          = bus.chipselect & ~bus.write_n;
  assign rd_s          = bus.chipselect & ~bus.read_n;
  assign data_wr_s     = wr_s & (bus.address == 2'd0);
  assign data_rd_s     = rd_s & (bus.address == 2'd0);
  assign status_wr_s   = wr_s & (bus.address == 2'd1);
  assign ctrl_wr_s     = wr_s & (bus.address == 2'd2);
  assign done_wr_s     = wr_s & (bus.address == 2'd3);
  assign overrun_evt_s = data_wr_s & busy_r;

  // Next-state logic: TX bits leave from shift_r[7], RX bits enter at shift_r[0]
  always_comb begin
    state_s    = state_r;
    hp_cnt_s   = hp_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    rx_byte_s  = rx_byte_r;
    sck_s      = sck_r;
    sdi_s      = sdi_r;
    busy_s     = busy_r;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sck_s = 1'b0;
        if (data_wr_s) begin
          state_s   = ST_LOW;
          shift_s   = bus.writedata[7:0];
          sdi_s     = bus.writedata[7];
          bit_cnt_s = 3'd7;
          hp_cnt_s  = div_r;
          busy_s    = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_LOW: begin
        if (hp_cnt_r == 8'd0) begin
          state_s  = ST_HIGH;
          sck_s    = 1'b1;
          hp_cnt_s = div_r;
        end else begin
          hp_cnt_s = hp_cnt_r - 8'd1;
        end
      end
      ST_HIGH: begin
        if (hp_cnt_r == 8'd0) begin
          shift_s  = {shift_r[6:0], sdo_sync_r};
          hp_cnt_s = div_r;
          sck_s    = 1'b0;
          if (bit_cnt_r == 3'd0) begin
            state_s    = ST_IDLE;
            busy_s     = 1'b0;
            rx_byte_s  = {shift_r[6:0], sdo_sync_r};
            complete_s = 1'b1;
          end else begin
            state_s   = ST_LOW;
            bit_cnt_s = bit_cnt_r - 3'd1;
            sdi_s     = shift_r[6];
          end
        end else begin
          hp_cnt_s = hp_cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sck_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Register read-back multiplexer; unused bits are zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (bus.address)
      2'd0:    rd_mux_s = {24'd0, rx_byte_r};
      2'd1:    rd_mux_s = {29'd0, overrun_r, rx_valid_r, busy_r};
      2'd2:    rd_mux_s = {16'd0, div_r, 6'd0, irq_en_r, cs_en_r};
      2'd3:    rd_mux_s = {31'd0, done_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous MISO line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdo_meta_r <= 1'b0;
      sdo_sync_r <= 1'b0;
    end else begin
      sdo_meta_r <= usb_sdo;
      sdo_sync_r <= sdo_meta_r;
    end
  end

  // FSM state, datapath and sticky flags; flag set always beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      hp_cnt_r   <= 8'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      rx_byte_r  <= 8'd0;
      sck_r      <= 1'b0;
      sdi_r      <= 1'b0;
      busy_r     <= 1'b0;
      cs_en_r    <= 1'b0;
      irq_en_r   <= 1'b0;
      div_r      <= 8'd4;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      done_r     <= 1'b0;
      irq_r      <= 1'b0;
      readdata_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      hp_cnt_r   <= hp_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      rx_byte_r  <= rx_byte_s;
      sck_r      <= sck_s;
      sdi_r      <= sdi_s;
      busy_r     <= busy_s;
      if (ctrl_wr_s) begin
        cs_en_r  <= bus.writedata[0];
        irq_en_r <= bus.writedata[1];
        div_r    <= bus.writedata[15:8];
      end
      rx_valid_r <= complete_s | (rx_valid_r & ~data_rd_s);
      overrun_r  <= overrun_evt_s | (overrun_r & ~status_wr_s);
      done_r     <= complete_s | (done_r & ~done_wr_s);
      irq_r      <= done_r & irq_en_r;
      readdata_r <= rd_mux_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = irq_r;
  assign usb_sck      = sck_r;
  assign usb_sdi      = sdi_r;
  assign usb_scs_n    = ~cs_en_r;

endmodule

// File: tb/tb_usb_spi_master.sv
// Self-checking bench for usb_spi_master: cycle-level behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized bus traffic.
module tb_usb_spi_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic usb_sck, usb_sdi, usb_scs_n, usb_sdo;
  int   checks = 0;
  int   errors = 0;

  usb_spi_master_if bus ();

  usb_spi_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .usb_sck  (usb_sck),
    .usb_sdi  (usb_sdi),
    .usb_scs_n(usb_scs_n),
    .usb_sdo  (usb_sdo)
  );

  always #5 clk = ~clk;

  // SPI slave: at DIV=0 it leads by half a bit so the MISO synchronizer latency is hidden
  logic [7:0] slave_tx = 8'h00;
  logic       slave_fast = 1'b0;
  int         rises = 0, falls = 0, base_r = 0, base_f = 0;
  logic [7:0] mosi_sr;
  always @(posedge usb_sck) begin
    rises   <= rises + 1;
    mosi_sr <= {mosi_sr[6:0], usb_sdi};
  end
  always @(negedge usb_sck) falls <= falls + 1;
  always_comb begin
    int sidx;
    sidx = slave_fast ? (rises - base_r) : (falls - base_f);
    usb_sdo = 1'b0;
    if (sidx >= 0 && sidx < 8) usb_sdo = slave_tx[3'(7 - sidx)];
  end

  // Behavioural model: a transfer is a cycle counter m_t since the DATA write edge
  logic       m_active, m_cs_en, m_irq_en, m_rxv, m_ovr, m_done, m_irq, m_sdi_idle;
  logic [7:0] m_div, m_d, m_tx, m_rx_pend, m_rx;
  logic [31:0] m_rd, m_sel;
  int         m_t;
  logic       b_wr, b_rd, m_comp, m_ovr_evt, m_start;
  logic       e_sck, e_sdi;

  always_comb begin
    b_wr      = bus.chipselect & ~bus.write_n;
    b_rd      = bus.chipselect & ~bus.read_n;
    m_comp    = m_active && (m_t == 16 * (int'(m_d) + 1) - 1);
    m_ovr_evt = b_wr && (bus.address == 2'd0) && m_active;
    m_start   = b_wr && (bus.address == 2'd0) && !m_active;
    case (bus.address)
      2'd0:    m_sel = {24'd0, m_rx};
      2'd1:    m_sel = {29'd0, m_ovr, m_rxv, m_active};
      2'd2:    m_sel = {16'd0, m_div, 6'd0, m_irq_en, m_cs_en};
      default: m_sel = {31'd0, m_done};
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0; m_cs_en <= 1'b0; m_irq_en <= 1'b0; m_rxv <= 1'b0;
      m_ovr <= 1'b0; m_done <= 1'b0; m_irq <= 1'b0; m_sdi_idle <= 1'b0;
      m_div <= 8'd4; m_d <= 8'd0; m_tx <= 8'd0; m_rx_pend <= 8'd0; m_rx <= 8'd0;
      m_rd <= 32'd0; m_t <= 0;
    end else begin
      m_rd  <= m_sel;
      m_irq <= m_done & m_irq_en;
      if (m_start) begin
        m_active <= 1'b1; m_t <= 0; m_d <= m_div;
        m_tx <= bus.writedata[7:0]; m_rx_pend <= slave_tx;
      end else if (m_comp) begin
        m_active <= 1'b0; m_rx <= m_rx_pend; m_sdi_idle <= m_tx[0];
      end else if (m_active) begin
        m_t <= m_t + 1;
      end
      m_ovr  <= m_ovr_evt | (m_ovr & ~(b_wr && bus.address == 2'd1));
      m_done <= m_comp | (m_done & ~(b_wr && bus.address == 2'd3));
      m_rxv  <= m_comp | (m_rxv & ~(b_rd && bus.address == 2'd0));
      if (b_wr && bus.address == 2'd2) begin
        m_cs_en <= bus.writedata[0]; m_irq_en <= bus.writedata[1]; m_div <= bus.writedata[15:8];
      end
    end
  end

  always_comb begin
    int per;
    int bi;
    per = 2 * (int'(m_d) + 1);
    bi = 0;
    e_sck = 1'b0;
    e_sdi = m_sdi_idle;
    if (m_active) begin
      e_sck = (m_t % per) >= (per / 2);
      bi = 7 - (m_t / per);
      e_sdi = m_tx[bi[2:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling clock edge and compare every output against the model
  task automatic tick();
    @(negedge clk);
    check("sck", {31'd0, usb_sck}, {31'd0, e_sck});
    check("sdi", {31'd0, usb_sdi}, {31'd0, e_sdi});
    check("scs_n", {31'd0, usb_scs_n}, {31'd0, ~m_cs_en});
    check("irq", {31'd0, bus.irq}, {31'd0, m_irq});
    check("readdata", bus.readdata, m_rd);
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    tick();
    bus_idle();
    v = bus.readdata;
  endtask

  task automatic arm_slave(input logic [7:0] b);
    slave_tx   = b;
    slave_fast = (m_div == 8'd0);
    base_r     = rises;
    base_f     = falls;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx);
    arm_slave(rx);
    wr(2'd0, {24'd0, tx});
  endtask

  task automatic busy_count(output int n);
    n = 0;
    bus.address = 2'd1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.readdata[0]) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_idle();
    bus.address = 2'd1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.readdata[0]) break;
    end
    check("wait_idle", {31'd0, bus.readdata[0]}, 32'd0);
  endtask

  logic [31:0] v;
  int          n;
  int          r;

  initial begin
    bus.address = 2'd0; bus.writedata = 32'd0;
    bus_idle();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset values and an 80-cycle byte at the default divider
    rd(2'd2, v);                     check("ctrl_reset", v, 32'h0000_0400);
    check("scs_n_reset", {31'd0, usb_scs_n}, 32'd1);
    wr(2'd2, 32'h0000_0401);
    check("scs_n_enabled", {31'd0, usb_scs_n}, 32'd0);
    start_xfer(8'h5A, 8'hC3);
    busy_count(n);                   check("busy_div4", n, 32'd80);
    check("mosi_div4", {24'd0, mosi_sr}, 32'h5A);
    rd(2'd1, v);                     check("status_after_div4", v, 32'h2);

    // Overrun: second DATA write ignored mid-transfer
    wr(2'd2, 32'h0000_0101);
    start_xfer(8'h81, 8'h7E);
    rd(2'd1, v);                     check("status_mid", v, 32'h3);
    repeat (3) tick();
    wr(2'd0, 32'h0000_0055);
    wait_idle();
    rd(2'd1, v);                     check("status_overrun", v, 32'h6);
    wr(2'd1, 32'd0);
    rd(2'd1, v);                     check("status_ovr_clr", v, 32'h2);
    rd(2'd0, v);                     check("rx_unchanged", v, 32'h7E);
    check("mosi_unchanged", {24'd0, mosi_sr}, 32'h81);

    // DIV=0, 0xA5 out, 0x3C back
    wr(2'd2, 32'h0000_0001);
    start_xfer(8'hA5, 8'h3C);
    busy_count(n);                   check("busy_div0", n, 32'd16);
    check("sck_pulses", rises - base_r, 32'd8);
    check("mosi_a5", {24'd0, mosi_sr}, 32'hA5);
    rd(2'd1, v);                     check("status_a5", v, 32'h2);
    rd(2'd0, v);                     check("rx_3c", v, 32'h3C);

    // irq: DONE write colliding with completion, then a later DONE write
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h0000_0003);
    start_xfer(8'h0F, 8'hF0);
    repeat (15) tick();
    wr(2'd3, 32'd0);
    check("irq_lag", {31'd0, bus.irq}, 32'd0);
    tick();
    check("irq_rise", {31'd0, bus.irq}, 32'd1);
    rd(2'd3, v);                     check("done_set_wins", v, 32'd1);
    wr(2'd3, 32'hFFFF_FFFF);
    check("irq_hold", {31'd0, bus.irq}, 32'd1);
    tick();
    check("irq_drop", {31'd0, bus.irq}, 32'd0);

    // DATA read on the completion edge keeps rx_valid
    rd(2'd0, v);
    start_xfer(8'h3C, 8'hA5);
    repeat (15) tick();
    rd(2'd0, v);
    rd(2'd1, v);                     check("rxv_kept", v, 32'h2);
    rd(2'd0, v);                     check("rx_a5", v, 32'hA5);

    // Reset pulse in the middle of a transfer
    wr(2'd2, 32'h0000_0101);
    start_xfer(8'h96, 8'h69);
    repeat (18) tick();
    check("sck_high_pre_reset", {31'd0, usb_sck}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("sck_reset", {31'd0, usb_sck}, 32'd0);
    check("readdata_reset", bus.readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rd(2'd1, v);                     check("status_post_reset", v, 32'd0);
    wr(2'd2, 32'h0000_0101);
    start_xfer(8'hFF, 8'h5B);
    wait_idle();
    check("mosi_ff", {24'd0, mosi_sr}, 32'hFF);
    rd(2'd0, v);                     check("rx_after_reset", v, 32'h5B);

    // Randomized register traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(99, 0));
      bus.address = 2'($urandom_range(3, 0));
      if (r < 12) begin
        if (!m_active) arm_slave(8'($urandom));
        bus.address = 2'd0; bus.writedata = $urandom; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end else if (r < 18) begin
        bus.address = 2'd1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end else if (r < 24) begin
        bus.address = 2'd3; bus.writedata = $urandom; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end else if (r < 32) begin
        bus.address = 2'd0; bus.chipselect = 1'b1; bus.read_n = 1'b0;
      end else if (r < 36) begin
        bus.chipselect = 1'b1; bus.read_n = 1'b0;
      end else if (r < 40 && !m_active) begin
        bus.address = 2'd2; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.writedata = {16'd0, 8'($urandom_range(3, 0)), 6'd0, 2'($urandom)};
      end else if (r < 46) begin
        bus.writedata = $urandom; bus.write_n = 1'b0; bus.read_n = 1'b0;
      end
      tick();
      bus_idle();
    end
    wait_idle();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_spi_master.md
USB_SPI_MASTER -- requirements
Module: usb_spi_master

Interface
REQ-001 Parameters: none; divider, chip select and interrupt enable are run-time registers.
REQ-002 The block SHALL use reset reset_n, asynchronous, active-low; clock clk.
REQ-003 Port list SHALL be:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- address  in  2  Avalon-MM word address
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  transfer-done interrupt
- usb_sck  out  1  serial clock to USB controller
- usb_sdi  out  1  serial data to USB controller (MOSI)
- usb_scs_n  out  1  active-low chip select to USB controller
- usb_sdo  in  1  serial data from USB controller (MISO), asynchronous

Function
REQ-004 Register map SHALL be:
- 0 DATA: write = TX byte [7:0]; read = RX byte [7:0]
- 1 STATUS: bit0 busy, bit1 rx_valid, bit2 overrun
- 2 CONTROL: bit0 cs_en, bit1 irq_en, bits[15:8] DIV
- 3 DONE: bit0 done flag
- All unused bits SHALL read 0.
REQ-005 readdata SHALL register the selected register every clk, independent of chipselect, so it is valid one cycle after address.
REQ-006 Write strobe = chipselect & ~write_n; read strobe = chipselect & ~read_n.
REQ-007 usb_scs_n SHALL equal ~cs_en, combinationally from the register, with no dependency on transfer state.
REQ-008 usb_sdo SHALL pass through a two-flop synchronizer before use.
REQ-009 Protocol SHALL be SPI mode 0, 8 bits, MSB first:
- usb_sck idles low
- usb_sdi updates when SCK falls
- usb_sdo is captured at SCK high
REQ-010 Each SCK half-period SHALL last DIV+1 clk cycles; one byte therefore keeps busy high for exactly 16*(DIV+1) cycles.
REQ-011 FSM states SHALL be IDLE, LOW (sck=0) and HIGH (sck=1), with a half-period counter and a 3-bit bit counter.
REQ-012 IDLE->LOW on a DATA write:
- load shift register with writedata[7:0]
- drive usb_sdi = bit7, set bit counter = 7, set busy = 1
REQ-013 LOW->HIGH when the half-period counter expires.
REQ-014 In HIGH, on the last cycle before expiry, the block SHALL shift the synchronized usb_sdo into the shift register LSB.
REQ-015 HIGH with bit counter != 0 SHALL, at expiry: decrement the counter, present the next TX bit on usb_sdi, and go to LOW.
REQ-016 HIGH with bit counter == 0 SHALL, at expiry:
- go to IDLE, clear busy
- copy the shift register to RX byte
- set rx_valid and done
REQ-017 A DATA write while busy SHALL be ignored and SHALL set overrun; an in-flight transfer is never disturbed.
REQ-018 A DATA read strobe SHALL clear rx_valid; if completion occurs in the same cycle, rx_valid SHALL remain set.
REQ-019 A STATUS write SHALL clear overrun; a simultaneous new overrun event SHALL leave it set.
REQ-020 A DONE write (any data) SHALL clear done; a simultaneous completion SHALL leave done set (set wins).
REQ-021 irq SHALL be registered, equal to done & irq_en, and lag done by one cycle.
REQ-022 A CONTROL write during a transfer SHALL take effect at the next half-period reload; cs_en changes apply immediately.
REQ-023 In IDLE: usb_sck = 0, and usb_sdi holds the last driven bit.

Reset
REQ-024 On reset_n low, all of the following SHALL be 0: readdata, irq, usb_sck, usb_sdi, busy, rx_valid, overrun, done, RX byte, cs_en, irq_en. DIV SHALL be 4, FSM SHALL be IDLE, usb_scs_n SHALL be 1.
REQ-025 Reset asserted mid-transfer SHALL abort immediately with no completion flags set; the next transfer after release SHALL start cleanly from IDLE.

Verification
REQ-026 The bench SHALL cover at least these scenarios:
- DIV=0, cs_en=1, write 0xA5 with a slave model returning 0x3C: 8 SCK pulses of 2-cycle period; usb_sdi sequence 1,0,1,0,0,1,0,1; busy high for 16 cycles; DATA reads 0x3C; STATUS reads 0x2.
- Reset values: DIV=4 (CONTROL reads 0x0400), usb_scs_n=1; a byte transfer takes 80 cycles.
- Second DATA write at cycle 5 of a transfer: first transfer completes unchanged; STATUS reads 0x3 mid-transfer, then 0x6 after completion; STATUS write -> 0x2.
- irq_en=1: irq rises 1 cycle after done; a DONE write in the same cycle as completion leaves done=1 and irq=1; a later DONE write drops irq after 1 cycle.
- reset_n pulsed low at bit 3 of a transfer: usb_sck=0 and busy=0 at once; STATUS reads 0 after release; the next 0xFF transfer returns the correct byte.
- DATA read coinciding with completion: rx_valid stays 1.
